mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared 32-bit memory port of the KGP_RISC core. Requester 0 is instruction fetch (read-only); requester 1 is load/store. The block picks a winner, drives the select of the 32-bit 2x1 address/data mux in front of memory, runs a fixed-latency access and returns read data with a one-cycle done pulse to the winner.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the single shared 32-bit memory port between instruction fetch
//   (requester 0, read-only) and load/store (requester 1). It latches the
//   winner's address/data, issues a one-cycle mem_en strobe, waits MEM_LAT
//   cycles for read data, captures it and pulses the winner's done.
//
//   Build option:
//     ARB_FIXED_PRIO_EN  defined   -> data requester (1) always wins a tie
//                        undefined -> round-robin tie-break using 'last'
//
//   Parameters:
//     MEM_LAT    memory read latency in cycles (1..15)
//
//   Ports:
//     clk, rst_n                 system clock, async active-low reset
//     req0, addr0                fetch request / address
//     req1, addr1, wdata1, we1   data request / address / store data / store
//     mem_rdata                  memory read data
//     sel                        mux select (0 = fetch path, 1 = data path)
//     mem_addr, mem_wdata        latched access address / store data
//     mem_en, mem_we             access strobe / write enable
//     rdata                      captured read data
//     done0, done1               one-cycle completion pulses
//     busy                       high whenever not IDLE
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for a request; arbitrates and latches the winner
//   ACCESS | mem_en strobe cycle
//   WAIT   | counting down the remaining read latency
//   DONE   | done pulse to the winner, then back to IDLE

module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  input  logic [31:0] mem_rdata,
  output logic        sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] rdata,
  output logic        done0,
  output logic        done1,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       grant1;

`ifndef ARB_FIXED_PRIO_EN
  logic       last;  // id of the most recent winner
`endif

  // Winner of the current IDLE cycle: 1 = data requester.
  always_comb begin
    grant1 = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      grant1 = 1'b1;
`else
      grant1 = ~last;
`endif
    end else begin
      grant1 = req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last      <= 1'b1;  // fetch wins the first tie
`endif
      sel       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel       <= grant1;
            mem_addr  <= grant1 ? addr1 : addr0;
            mem_wdata <= grant1 ? wdata1 : 32'h0;
            mem_we    <= grant1 & we1;
`ifndef ARB_FIXED_PRIO_EN
            last      <= grant1;
`endif
            cnt       <= CNT_INIT;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS, WAIT: begin
          if (cnt == 4'd0) begin
            // mem_we is still the latched store flag of this access
            if (!mem_we) rdata <= mem_rdata;
            done0 <= ~sel;
            done1 <= sel;
            state <= DONE;
          end else begin
            cnt   <= cnt - 4'd1;
            state <= WAIT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter. Two lanes run in
// parallel: one DUT with MEM_LAT=2 and one with MEM_LAT=1. Per-requester
// drivers push issued transactions into queues; a per-lane monitor predicts
// grants, strobe timing, done timing and read data from the port rules at
// transaction level and compares every cycle.

module tb_mem_port_arbiter;

  localparam int NTX = 40;
  localparam int TMO = 64;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ndone  = 0;

  always #5 clk = ~clk;

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input int lane_id, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got 0x%08h expected 0x%08h at %0t",
               lane_id, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 2 : 1;

    logic        req0, req1, we1;
    logic [31:0] addr0, addr1, wdata1, mem_rdata;
    logic        sel, mem_en, mem_we, done0, done1, busy;
    logic [31:0] mem_addr, mem_wdata, rdata;

    txn_t q0[$];
    txn_t q1[$];

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .addr0     (addr0),
      .req1      (req1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .we1       (we1),
      .mem_rdata (mem_rdata),
      .sel       (sel),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .rdata     (rdata),
      .done0     (done0),
      .done1     (done1),
      .busy      (busy)
    );

    // Memory: read data valid only in cycle en+LAT-1, garbage otherwise.
    initial begin : memory
      int          cd;
      logic [31:0] a;
      cd = -1;
      a = '0;
      mem_rdata = '0;
      forever begin
        @(posedge clk); #1;
        if (!rst_n) cd = -1;
        else if (mem_en) begin a = mem_addr; cd = LAT - 1; end
        else if (cd >= 0) cd--;
        mem_rdata = (cd == 0) ? mem_fn(a) : $urandom;
      end
    end

    task automatic set_req(input int k, input logic v);
      if (k == 0) req0 = v; else req1 = v;
    endtask

    task automatic run_req(input int k);
      txn_t t;
      int   gap;
      bit   got, aborted, dropped;
      gap = 0;
      set_req(k, 1'b0);
      if (k == 0) addr0 = '0;
      else begin addr1 = '0; we1 = 1'b0; wdata1 = '0; end
      for (int c = 0; c < 100 && rst_n !== 1'b1; c++) begin @(posedge clk); #1; end
      for (int i = 0; i < NTX; i++) begin
        if (gap > 0) begin
          set_req(k, 1'b0);
          repeat (gap) begin @(posedge clk); #1; end
        end
        for (int c = 0; c < 100 && !rst_n; c++) begin @(posedge clk); #1; end
        t.addr  = $urandom;
        t.we    = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        t.wdata = (k == 1) ? $urandom : 32'h0;
        if (k == 0) begin
          addr0 = t.addr;
          q0.push_back(t);
        end else begin
          addr1 = t.addr; we1 = t.we; wdata1 = t.wdata;
          q1.push_back(t);
        end
        set_req(k, 1'b1);
        got = 0; aborted = 0; dropped = 0;
        for (int c = 0; c < TMO && !got && !aborted; c++) begin
          @(posedge clk); #1;
          if (!rst_n) aborted = 1;
          else if ((k == 0) ? done0 : done1) got = 1;
          else if (!dropped && mem_en && sel == 1'(k) && $urandom_range(0, 4) == 0) begin
            set_req(k, 1'b0);  // drop the request right after the grant
            dropped = 1;
          end
        end
        gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (aborted) begin
          set_req(k, 1'b0);
          gap = 0;
          for (int c = 0; c < 100 && !rst_n; c++) begin @(posedge clk); #1; end
        end else if (!got) begin
          checks++;
          errors++;
          $display("FAIL lane%0d done%0d_timeout: got no done expected done within %0d cycles",
                   g, k, TMO);
          set_req(k, 1'b0);
        end
      end
      set_req(k, 1'b0);
      ndone++;
    endtask

    initial run_req(0);
    initial run_req(1);

    // Transaction-level monitor / scoreboard.
    int          cyc = 0;
    int          en_cyc = 0;
    bit          active = 0, cur = 0, last_m = 1, prev_free = 1, pr0 = 0, pr1 = 0;
    logic [31:0] rdata_m = '0;

    always @(negedge clk) begin
      txn_t t;
      bit   w, fin;
      int   qs;
      if (!rst_n) begin
        chk(g, "reset_ctrl", 32'({sel, mem_en, mem_we, done0, done1, busy}), 32'h0);
        chk(g, "reset_mem_addr", mem_addr, 32'h0);
        chk(g, "reset_mem_wdata", mem_wdata, 32'h0);
        chk(g, "reset_rdata", rdata, 32'h0);
        q0.delete(); q1.delete();
        active = 0; last_m = 1; rdata_m = '0;
        pr0 = 0; pr1 = 0; prev_free = 1;
      end else begin
        cyc++;
        fin = 0;
        if (prev_free && (pr0 || pr1)) begin
`ifdef ARB_FIXED_PRIO_EN
          w = pr1;
`else
          w = (pr0 && pr1) ? ~last_m : pr1;
`endif
          chk(g, "mem_en_grant", 32'(mem_en), 32'h1);
          chk(g, "sel", 32'(sel), 32'(w));
          qs = w ? q1.size() : q0.size();
          if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d pending_txn: got empty queue expected a txn for requester %0d",
                     g, w);
          end else begin
            t = w ? q1[0] : q0[0];
            chk(g, "mem_addr", mem_addr, t.addr);
            chk(g, "mem_we", 32'(mem_we), 32'(w & t.we));
            if (!w || t.we) chk(g, "mem_wdata", mem_wdata, w ? t.wdata : 32'h0);
          end
          last_m = w; cur = w; active = 1; en_cyc = cyc;
        end else begin
          chk(g, "mem_en_quiet", 32'(mem_en), 32'h0);
        end
        if (active && cyc == en_cyc + LAT) begin
          chk(g, "done", 32'({done1, done0}), cur ? 32'h2 : 32'h1);
          qs = cur ? q1.size() : q0.size();
          if (qs > 0) begin
            t = cur ? q1.pop_front() : q0.pop_front();
            if (!(cur && t.we)) rdata_m = mem_fn(t.addr);
          end
          fin = 1;
        end else begin
          chk(g, "no_done", 32'({done1, done0}), 32'h0);
        end
        chk(g, "busy", 32'(busy), 32'(active));
        chk(g, "rdata", rdata, rdata_m);
        prev_free = !active;
        if (fin) active = 0;
        pr0 = req0;
        pr1 = req1;
      end
    end
  end

  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    // Hit lane 0 (MEM_LAT=2) with reset during its WAIT cycle.
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (lane[0].mem_en) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL lane0 wait_for_access: got no mem_en expected one within 200 cycles");
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 20000 && ndone < 4; c++) @(posedge clk);
    if (ndone < 4) begin
      checks++;
      errors++;
      $display("FAIL drivers_finish: got %0d finished expected 4", ndone);
    end
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
